// File: rtl/rp_sd_arb_pkg.sv
// Shared types and constants for the RPxx -> SD-card arbiter slice.
//   sdarbState_t : arbiter sequencer states
//   sdop*        : SD operation codes carried on sdOP
//   *_DEF        : default geometry used by the interface and the top
package rp_sd_pkg;

  localparam int unsigned NUM_DRV_DEF = 8;
  localparam int unsigned OP_W_DEF    = 3;
  localparam int unsigned LSA_W_DEF   = 21;

  localparam logic [OP_W_DEF-1:0] sdopNOP   = 3'd0;
  localparam logic [OP_W_DEF-1:0] sdopRD    = 3'd1;
  localparam logic [OP_W_DEF-1:0] sdopWR    = 3'd2;
  localparam logic [OP_W_DEF-1:0] sdopWRCHK = 3'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    BUSY  = 3'd2,
    ACK   = 3'd3,
    DRAIN = 3'd4
  } sdarbState_t;

endpackage

// File: rtl/rp_sd_arb_if.sv
// Drive-array / SD-controller signal bundle for rp_sd_arb.
//   master : arbiter view (consumes drive requests and sdDONE, drives SD request/ACKs)
//   slave  : environment view (drive models + SD controller)
//   drvREQ/drvOP/drvLSA : per-drive request level, op, sector address (packed per drive)
//   drvACK              : one-hot completion pulse back to the drives
//   sdREQ/sdOP/sdLSA    : latched request to the SD controller
//   sdDONE              : SD op-complete pulse
//   sdSCAN/sdBUSY/sdTMO : granted unit, grant outstanding, sticky watchdog timeout
interface rp_sd_arb_if
  import rp_sd_pkg::*;
#(
  parameter int unsigned NUM_DRV = NUM_DRV_DEF,
  parameter int unsigned OP_W    = OP_W_DEF,
  parameter int unsigned LSA_W   = LSA_W_DEF
);

  localparam int unsigned SEL_W = $clog2(NUM_DRV);

  logic [NUM_DRV-1:0]       drvREQ;
  logic [NUM_DRV*OP_W-1:0]  drvOP;
  logic [NUM_DRV*LSA_W-1:0] drvLSA;
  logic [NUM_DRV-1:0]       drvACK;
  logic                     sdREQ;
  logic [OP_W-1:0]          sdOP;
  logic [LSA_W-1:0]         sdLSA;
  logic                     sdDONE;
  logic [SEL_W-1:0]         sdSCAN;
  logic                     sdBUSY;
  logic                     sdTMO;

  modport master (
    input  drvREQ, drvOP, drvLSA, sdDONE,
    output drvACK, sdREQ, sdOP, sdLSA, sdSCAN, sdBUSY, sdTMO
  );

  modport slave (
    output drvREQ, drvOP, drvLSA, sdDONE,
    input  drvACK, sdREQ, sdOP, sdLSA, sdSCAN, sdBUSY, sdTMO
  );

endinterface

// File: rtl/rp_sd_arb_rr_pick.sv
// Rotating-priority picker: first set bit of req scanning last+1, last+2, ...
// modulo NUM_DRV (NUM_DRV must be a power of 2, >= 2).
//   req    : request vector
//   last   : most recently served drive (lowest priority)
//   winner : selected drive, valid only when valid=1
//   valid  : any request present
module rp_rr_pick #(
  parameter  int unsigned NUM_DRV = 8,
  localparam int unsigned SEL_W   = $clog2(NUM_DRV)
) (
  input  logic [NUM_DRV-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   winner,
  output logic               valid
);

  // Walk from the lowest priority back to the highest so the closest requester wins;
  // SEL_W-bit addition wraps naturally because NUM_DRV is a power of 2.
  always_comb begin
    winner = '0;
    valid  = |req;
    for (int i = NUM_DRV; i >= 1; i--) begin
      if (req[last + SEL_W'(i)]) winner = last + SEL_W'(i);
    end
  end

endmodule

// File: rtl/rp_sd_arb.sv
// Round-robin arbiter/sequencer sharing one SD-card controller among NUM_DRV drives.
// Latches the winner's op/LSA, holds sdREQ for the whole sector op, pulses the
// winner's drvACK for one clock, then waits for that drive to drop its request.
//   clk   : system clock
//   rst   : asynchronous reset, active-low
//   clr   : synchronous controller clear (mbINIT), active-high
//   bus   : rp_sd_arb_if.master (drive requests, SD request/done, status)
// Optional build macro RP_SDARB_WDOG_EN adds a BUSY watchdog (parameter WDOG_CYC)
// that force-completes a stuck op and sets sticky sdTMO; otherwise sdTMO is 0.
module rp_sd_arb
  import rp_sd_pkg::*;
#(
  parameter int unsigned NUM_DRV  = NUM_DRV_DEF,
  parameter int unsigned OP_W     = OP_W_DEF,
  parameter int unsigned LSA_W    = LSA_W_DEF
`ifdef RP_SDARB_WDOG_EN
  , parameter int unsigned WDOG_CYC = 2**24
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  rp_sd_arb_if.master      bus
);

  localparam int unsigned SEL_W = $clog2(NUM_DRV);

  sdarbState_t        state_q, state_d;
  logic [NUM_DRV-1:0] drv_ack_q, drv_ack_d;
  logic               sd_req_q, sd_req_d;
  logic [OP_W-1:0]    sd_op_q, sd_op_d;
  logic [LSA_W-1:0]   sd_lsa_q, sd_lsa_d;
  logic [SEL_W-1:0]   sd_scan_q, sd_scan_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic               sd_busy_q, sd_busy_d;
  logic               sd_tmo_q, sd_tmo_d;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               wdog_exp_c;

  // Unpacked per-drive views of the packed op/LSA buses
  logic [OP_W-1:0]    drv_op_arr  [NUM_DRV];
  logic [LSA_W-1:0]   drv_lsa_arr [NUM_DRV];

  for (genvar g = 0; g < NUM_DRV; g++) begin : g_unpack
    assign drv_op_arr[g]  = bus.drvOP[g*OP_W +: OP_W];
    assign drv_lsa_arr[g] = bus.drvLSA[g*LSA_W +: LSA_W];
  end

  rp_rr_pick #(
    .NUM_DRV (NUM_DRV)
  ) u_pick (
    .req    (bus.drvREQ),
    .last   (last_q),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

`ifdef RP_SDARB_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Counts BUSY cycles; cleared on BUSY entry, saturates at the limit
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == GRANT) begin
      wdog_d = '0;
    end else if ((state_q == BUSY) && (wdog_q != WDOG_W'(WDOG_CYC))) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wdog_q <= '0;
    else      wdog_q <= wdog_d;
  end

  // Expires on the WDOG_CYC-th BUSY cycle
  assign wdog_exp_c = (state_q == BUSY) && (wdog_q == WDOG_W'(WDOG_CYC - 1));
`else
  assign wdog_exp_c = 1'b0;
`endif

  // Sequencer next-state and registered outputs
  always_comb begin
    state_d   = state_q;
    drv_ack_d = '0;
    sd_req_d  = sd_req_q;
    sd_op_d   = sd_op_q;
    sd_lsa_d  = sd_lsa_q;
    sd_scan_d = sd_scan_q;
    last_d    = last_q;
    sd_tmo_d  = sd_tmo_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          sd_scan_d = pick_idx;
          sd_op_d   = drv_op_arr[pick_idx];
          sd_lsa_d  = drv_lsa_arr[pick_idx];
          state_d   = GRANT;
        end
      end
      GRANT: begin
        sd_req_d = 1'b1;
        state_d  = BUSY;
      end
      BUSY: begin
        // A real sdDONE takes precedence over a coincident watchdog expiry
        if (bus.sdDONE || wdog_exp_c) begin
          sd_req_d  = 1'b0;
          drv_ack_d = NUM_DRV'(1) << sd_scan_q;
          last_d    = sd_scan_q;
          state_d   = ACK;
          if (!bus.sdDONE) sd_tmo_d = 1'b1;
        end
      end
      ACK: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        // Hold off re-arbitration until the served drive finishes its 4-phase handshake
        if (!bus.drvREQ[sd_scan_q]) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear aborts any op without ACK; round-robin pointer survives
    if (clr) begin
      state_d   = IDLE;
      sd_req_d  = 1'b0;
      drv_ack_d = '0;
      last_d    = last_q;
      sd_tmo_d  = 1'b0;
    end

    sd_busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      drv_ack_q <= '0;
      sd_req_q  <= 1'b0;
      sd_op_q   <= '0;
      sd_lsa_q  <= '0;
      sd_scan_q <= '0;
      last_q    <= SEL_W'(NUM_DRV - 1);
      sd_busy_q <= 1'b0;
      sd_tmo_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      drv_ack_q <= drv_ack_d;
      sd_req_q  <= sd_req_d;
      sd_op_q   <= sd_op_d;
      sd_lsa_q  <= sd_lsa_d;
      sd_scan_q <= sd_scan_d;
      last_q    <= last_d;
      sd_busy_q <= sd_busy_d;
      sd_tmo_q  <= sd_tmo_d;
    end
  end

  assign bus.drvACK = drv_ack_q;
  assign bus.sdREQ  = sd_req_q;
  assign bus.sdOP   = sd_op_q;
  assign bus.sdLSA  = sd_lsa_q;
  assign bus.sdSCAN = sd_scan_q;
  assign bus.sdBUSY = sd_busy_q;
  assign bus.sdTMO  = sd_tmo_q;

endmodule
